branch_predict_unit: RTL

- Parametrised successor to the combinational branch resolver, for the pipelined RV32I core.
- Fetch side: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters gives a same-cycle predicted-taken flag and target.
- Execute side: resolves branch/JAL/JALR, produces PC+Imm, PC+4 and the redirect PC, flags mispredicts, and trains the tables.
- Keeps saturating statistics counters for control instructions and mispredicts.

---
 rtl/branch_pkg.sv | 24 ++
 rtl/btb_table.sv | 99 +++++++++
 rtl/branch_predict_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch prediction unit: 2-bit counter
// encoding, control-instruction kinds and the saturating counter update.
package branch_pkg;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t SNT = 2'b00;
  localparam bht_ctr_t WNT = 2'b01;
  localparam bht_ctr_t WT  = 2'b10;
  localparam bht_ctr_t ST  = 2'b11;

  typedef enum logic [1:0] {
    CK_NONE = 2'd0,
    CK_BR   = 2'd1,
    CK_JAL  = 2'd2,
    CK_JALR = 2'd3
  } ctrl_kind_e;

  function automatic bht_ctr_t sat_update(input bht_ctr_t ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : bht_ctr_t'(ctr + 2'd1);
    return (ctr == SNT) ? SNT : bht_ctr_t'(ctr - 2'd1);
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: async lookup port plus one read-modify-write
// training port; reset clears valid bits and parks counters at weakly-not-taken.
module btb_table
  import branch_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int IDX_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IDX_W-1:0]          rd_idx_i,
  output logic                      rd_valid_o,
  output logic [PC_W-IDX_W-3:0]     rd_tag_o,
  output logic [PC_W-1:0]           rd_target_o,
  output bht_ctr_t                  rd_ctr_o,
  input  logic                      upd_en_i,
  input  ctrl_kind_e                upd_kind_i,
  input  logic [IDX_W-1:0]          upd_idx_i,
  input  logic [PC_W-IDX_W-3:0]     upd_tag_i,
  input  logic [PC_W-1:0]           upd_target_i,
  input  logic                      upd_taken_i
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic              valid_q  [DEPTH];
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [PC_W-1:0]   target_q [DEPTH];
  bht_ctr_t          ctr_q    [DEPTH];

  logic              hit;
  logic              we;
  logic              valid_d;
  logic [TAG_W-1:0]  tag_d;
  logic [PC_W-1:0]   target_d;
  bht_ctr_t          ctr_d;

  assign rd_valid_o  = valid_q[rd_idx_i];
  assign rd_tag_o    = tag_q[rd_idx_i];
  assign rd_target_o = target_q[rd_idx_i];
  assign rd_ctr_o    = ctr_q[rd_idx_i];

  assign hit = valid_q[upd_idx_i] && (tag_q[upd_idx_i] == upd_tag_i);

  always_comb begin
    we       = 1'b0;
    valid_d  = valid_q[upd_idx_i];
    tag_d    = tag_q[upd_idx_i];
    target_d = target_q[upd_idx_i];
    ctr_d    = ctr_q[upd_idx_i];
    if (upd_en_i) begin
      unique case (upd_kind_i)
        CK_JAL: begin
          we       = 1'b1;
          valid_d  = 1'b1;
          tag_d    = upd_tag_i;
          target_d = upd_target_i;
          ctr_d    = ST;
        end
        CK_BR: begin
          if (hit) begin
            we    = 1'b1;
            ctr_d = sat_update(ctr_q[upd_idx_i], upd_taken_i);
            if (upd_taken_i) target_d = upd_target_i;
          end else if (upd_taken_i) begin
            // Only taken branches earn an entry; not-taken ones fall through anyway.
            we       = 1'b1;
            valid_d  = 1'b1;
            tag_d    = upd_tag_i;
            target_d = upd_target_i;
            ctr_d    = WT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
    end else if (we) begin
      valid_q[upd_idx_i] <= valid_d;
      ctr_q[upd_idx_i]   <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[upd_idx_i]    <= tag_d;
      target_q[upd_idx_i] <= target_d;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-side BTB prediction and execute-side branch/JAL/JALR resolution with
// mispredict redirect, table training and saturating statistics counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [31:0]       ex_imm,
  input  logic              ex_branch,
  input  logic              ex_jal,
  input  logic              ex_jalr,
  input  logic [31:0]       ex_alu_result,
  input  logic              ex_pred_taken,
  input  logic [31:0]       ex_pred_target,
  output logic [31:0]       pc_imm,
  output logic [31:0]       pc_four,
  output logic [31:0]       br_pc,
  output logic              pc_sel,
  output logic [CNT_W-1:0]  ctrl_count,
  output logic [CNT_W-1:0]  mispred_count
);

  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [PC_W-1:0]   rd_target;
  bht_ctr_t          rd_ctr;
  logic              unused_if_lsb;

  ctrl_kind_e        kind;
  logic              ctrl;
  logic [31:0]       pc_ext;
  logic              act_taken;
  logic [31:0]       act_target;
  logic              mispredict;
  logic              upd_en;

  logic [CNT_W-1:0]  ctrl_count_q, ctrl_count_d;
  logic [CNT_W-1:0]  mispred_count_q, mispred_count_d;

  btb_table #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W)
  ) u_btb (
    .clk          (clk),
    .reset        (reset),
    .rd_idx_i     (if_pc[IDX_W+1:2]),
    .rd_valid_o   (rd_valid),
    .rd_tag_o     (rd_tag),
    .rd_target_o  (rd_target),
    .rd_ctr_o     (rd_ctr),
    .upd_en_i     (upd_en),
    .upd_kind_i   (kind),
    .upd_idx_i    (ex_pc[IDX_W+1:2]),
    .upd_tag_i    (ex_pc[PC_W-1:IDX_W+2]),
    .upd_target_i (act_target[PC_W-1:0]),
    .upd_taken_i  (act_taken)
  );

  assign unused_if_lsb = ^if_pc[1:0];

  assign pred_taken  = rd_valid & (rd_tag == if_pc[PC_W-1:IDX_W+2]) & rd_ctr[1];
  assign pred_target = {{(32-PC_W){1'b0}}, rd_target};

  // Illegal multi-flag encodings resolve with jalr > jal > branch priority.
  always_comb begin
    kind = CK_NONE;
    if (ex_valid) begin
      if (ex_jalr)        kind = CK_JALR;
      else if (ex_jal)    kind = CK_JAL;
      else if (ex_branch) kind = CK_BR;
    end
  end

  assign ctrl       = (kind != CK_NONE);
  assign pc_ext     = {{(32-PC_W){1'b0}}, ex_pc};
  assign pc_imm     = pc_ext + ex_imm;
  assign pc_four    = pc_ext + 32'd4;
  assign act_taken  = (kind == CK_BR) ? ex_alu_result[0] : 1'b1;
  assign act_target = (kind == CK_JALR) ? {ex_alu_result[31:1], 1'b0} : pc_imm;

  assign mispredict = ctrl & ((ex_pred_taken != act_taken) |
                              (act_taken & (ex_pred_target != act_target)));
  assign pc_sel     = mispredict;
  assign br_pc      = mispredict ? (act_taken ? act_target : pc_four) : 32'd0;

  assign upd_en = ctrl & ~reset & (kind != CK_JALR);

  always_comb begin
    ctrl_count_d    = ctrl_count_q;
    mispred_count_d = mispred_count_q;
    if (ctrl)       ctrl_count_d    = sat_inc(ctrl_count_q);
    if (mispredict) mispred_count_d = sat_inc(mispred_count_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_count_q    <= '0;
      mispred_count_q <= '0;
    end else begin
      ctrl_count_q    <= ctrl_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign ctrl_count    = ctrl_count_q;
  assign mispred_count = mispred_count_q;

endmodule
